// File: rtl/encoder8_3_arb.sv
// encoder8_3_arb: 8-to-3 priority encoder with a sticky pending-request
// register and a valid/ack handshake. Requests are collected in pend,
// the winning index is presented on Y with V, and the pending bit is
// retired when the consumer acknowledges it. Every output is a flop.
module encoder8_3_arb #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] D,
    input  logic       ack,
    output logic [2:0] Y,
    output logic       V,
    output logic [7:0] pend,
    output logic       ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_y;
    logic       r_v;
    logic [7:0] r_pend;
    logic       r_ovf;

    logic [7:0] w_clr;
    logic [7:0] w_pendNext;
    logic       w_ovfNext;
    logic [2:0] w_prioIdx;

    // Index of the winning pending bit; the later loop hit wins, so the
    // scan direction decides whether the highest or lowest index is chosen.
    function automatic logic [2:0] prioIndex(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (p[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (p[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Clear mask, next pending value and overflow detect; a same-cycle set
    // from D is OR-ed in after the clear so a re-posted request survives.
    always_comb begin
        w_clr = 8'h00;
        if (r_v && ack) begin
            w_clr = 8'h01 << r_y;
        end
        w_pendNext = (r_pend & ~w_clr) | D;
        w_ovfNext  = |(D & r_pend & ~w_clr);
        w_prioIdx  = prioIndex(r_pend);
    end

    // Pending register and the one-cycle overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 8'h00;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pendNext;
            r_ovf  <= w_ovfNext;
        end
    end

    // Grant FSM: issue from the registered pend in IDLE, hold the code in
    // VALID until acknowledged; Y keeps its last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= 3'd0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (E && (r_pend != 8'h00)) begin
                        r_y     <= w_prioIdx;
                        r_v     <= 1'b1;
                        r_state <= VALID;
                    end else begin
                        r_v <= 1'b0;
                    end
                end
                VALID: begin
                    if (ack) begin
                        r_v     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_v     <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Y    = r_y;
    assign V    = r_v;
    assign pend = r_pend;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_encoder8_3_arb.sv
// Testbench for encoder8_3_arb: runs a highest-first and a lowest-first
// instance side by side against a cycle-level behavioural model, with
// directed scenarios followed by a randomized run.
module tb_encoder8_3_arb;

    logic       clk;
    logic       rst;
    logic       E;
    logic [7:0] D;
    logic       ack;

    logic [2:0] yHi, yLo;
    logic       vHi, vLo;
    logic [7:0] pendHi, pendLo;
    logic       ovfHi, ovfLo;

    int checks;
    int passed;

    // Model state, index 0 = highest-first, index 1 = lowest-first
    int mPend [2];
    int mY    [2];
    bit mV    [2];
    bit mOvf  [2];

    encoder8_3_arb #(.HIGH_FIRST(1'b1)) dutHi (
        .clk (clk), .rst (rst), .E (E), .D (D), .ack (ack),
        .Y (yHi), .V (vHi), .pend (pendHi), .ovf (ovfHi)
    );

    encoder8_3_arb #(.HIGH_FIRST(1'b0)) dutLo (
        .clk (clk), .rst (rst), .E (E), .D (D), .ack (ack),
        .Y (yLo), .V (vLo), .pend (pendLo), .ovf (ovfLo)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Highest set bit via log2 of (p+1); lowest via isolating p & -p
    function automatic int highIdx(input int p);
        return $clog2(p + 1) - 1;
    endfunction

    function automatic int lowIdx(input int p);
        return $clog2(p & (-p));
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mPend[k] = 0;
            mY[k]    = 0;
            mV[k]    = 1'b0;
            mOvf[k]  = 1'b0;
        end
    endfunction

    // One clock edge of the behavioural rules, using pre-edge inputs
    function automatic void modelStep(input bit e, input int d, input bit a);
        int clr;
        for (int k = 0; k < 2; k++) begin
            clr = (mV[k] && a) ? (1 << mY[k]) : 0;
            mOvf[k] = ((d & mPend[k] & ~clr & 255) != 0);
            if (!mV[k]) begin
                if (e && mPend[k] != 0) begin
                    mY[k] = (k == 0) ? highIdx(mPend[k]) : lowIdx(mPend[k]);
                    mV[k] = 1'b1;
                end
            end else if (a) begin
                mV[k] = 1'b0;
            end
            mPend[k] = ((mPend[k] & ~clr) | d) & 255;
        end
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_hi_y"},    8'(yHi),    8'(mY[0]));
        checkVal({tag, "_hi_v"},    8'(vHi),    8'(mV[0]));
        checkVal({tag, "_hi_pend"}, pendHi,     8'(mPend[0]));
        checkVal({tag, "_hi_ovf"},  8'(ovfHi),  8'(mOvf[0]));
        checkVal({tag, "_lo_y"},    8'(yLo),    8'(mY[1]));
        checkVal({tag, "_lo_v"},    8'(vLo),    8'(mV[1]));
        checkVal({tag, "_lo_pend"}, pendLo,     8'(mPend[1]));
        checkVal({tag, "_lo_ovf"},  8'(ovfLo),  8'(mOvf[1]));
    endtask

    // Drive inputs, take one edge, advance the model, sample 1 after edge
    task automatic applyStimulus(input bit e, input logic [7:0] d, input bit a, input string tag);
        E   = e;
        D   = d;
        ack = a;
        @(posedge clk);
        modelStep(e, int'(d), a);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        E   = 1'b0;
        D   = 8'h00;
        ack = 1'b0;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b0;
        E   = 1'b0;
        D   = 8'h00;
        ack = 1'b0;
        #2;
        doReset();

        // Two requests, ack held: hi issues 5 then 2, lo issues 2 then 5
        applyStimulus(1'b1, 8'h24, 1'b1, "r28_post");
        applyStimulus(1'b1, 8'h00, 1'b1, "r28_g1");
        checkVal("r28_hi_first", 8'(yHi), 8'd5);
        checkVal("r29_lo_first", 8'(yLo), 8'd2);
        applyStimulus(1'b1, 8'h00, 1'b1, "r28_ack1");
        applyStimulus(1'b1, 8'h00, 1'b1, "r28_g2");
        checkVal("r28_hi_second", 8'(yHi), 8'd2);
        checkVal("r29_lo_second", 8'(yLo), 8'd5);
        checkVal("r28_v_second", 8'(vHi), 8'd1);
        applyStimulus(1'b1, 8'h00, 1'b1, "r28_ack2");
        checkVal("r28_pend_empty", pendHi, 8'h00);

        // Re-post of the bit being acknowledged survives without overflow
        doReset();
        applyStimulus(1'b1, 8'h08, 1'b0, "r30_post");
        applyStimulus(1'b1, 8'h00, 1'b0, "r30_grant");
        checkVal("r30_y3", 8'(yHi), 8'd3);
        applyStimulus(1'b1, 8'h08, 1'b1, "r30_ackset");
        checkVal("r30_pend_kept", pendHi, 8'h08);
        checkVal("r30_no_ovf", 8'(ovfHi), 8'd0);
        applyStimulus(1'b1, 8'h00, 1'b0, "r30_reissue");
        checkVal("r30_reissue_v", 8'(vHi), 8'd1);
        checkVal("r30_reissue_y", 8'(yHi), 8'd3);

        // Duplicate request with no ack: single-cycle overflow pulse
        doReset();
        applyStimulus(1'b0, 8'h01, 1'b0, "r31_post");
        applyStimulus(1'b0, 8'h01, 1'b0, "r31_dup");
        checkVal("r31_ovf_hi", 8'(ovfHi), 8'd1);
        checkVal("r31_pend", pendHi, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b0, "r31_after");
        checkVal("r31_ovf_lo", 8'(ovfHi), 8'd0);

        // Enable low collects requests; raising it issues the top index
        doReset();
        applyStimulus(1'b0, 8'hFF, 1'b0, "r32_collect");
        applyStimulus(1'b0, 8'h00, 1'b0, "r32_hold");
        checkVal("r32_v_off", 8'(vHi), 8'd0);
        applyStimulus(1'b1, 8'h00, 1'b0, "r32_enable");
        checkVal("r32_y7", 8'(yHi), 8'd7);
        applyStimulus(1'b0, 8'h00, 1'b0, "r32_e_drop");
        checkVal("r32_v_held", 8'(vHi), 8'd1);

        // Asynchronous reset in the middle of a valid code
        doReset();
        applyStimulus(1'b1, 8'h81, 1'b0, "r33_post");
        applyStimulus(1'b1, 8'h00, 1'b0, "r33_grant");
        checkVal("r33_v_before", 8'(vHi), 8'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("r33_async");
        checkVal("r33_pend_cleared", pendHi, 8'h00);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b1, "r33_idle1");
        applyStimulus(1'b1, 8'h00, 1'b0, "r33_idle2");
        applyStimulus(1'b1, 8'h40, 1'b0, "r33_newpost");
        applyStimulus(1'b1, 8'h00, 1'b0, "r33_newgrant");

        // Randomized traffic against the model
        doReset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rd;
            rd = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            applyStimulus(($urandom_range(0, 3) != 0), rd, $urandom_range(0, 1) == 1, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/encoder8_3_arb.md
ENCODER8_3_ARB -- requirements
Module: encoder8_3_arb

Interface
REQ-001 Parameter: HIGH_FIRST, default 1, selects priority: 1 = highest pending index wins, 0 = lowest pending index wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 E  input  1  encode enable; when 0 no new code is issued.
REQ-005 D  input  8  request lines; a 1 on D[i] in any cycle posts request i.
REQ-006 ack  input  1  consumer accepts the presented code.
REQ-007 Y  output  3  encoded index of the granted request.
REQ-008 V  output  1  Y valid.
REQ-009 pend  output  8  pending-request register.
REQ-010 ovf  output  1  one-cycle pulse: a request was posted for an index already pending.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 Capture: each cycle, pend SHALL be updated to (pend & ~clr) | D, where clr is the one-hot of Y when V=1 and ack=1, else 0.
REQ-013 A set from D SHALL win over a same-cycle clear of the same bit, so no request is lost.
REQ-014 ovf SHALL pulse for exactly one cycle when, for any i, D[i]=1 and pend[i]=1 and bit i is not cleared that cycle; otherwise ovf=0.
REQ-015 FSM states: IDLE, VALID.
REQ-016 IDLE: if E=1 and pend is non-zero, Y SHALL load the priority index of pend per HIGH_FIRST, V SHALL go to 1 and the FSM SHALL go to VALID; otherwise remain in IDLE with V=0.
REQ-017 Priority selection SHALL use the registered pend value, not the same-cycle D.
REQ-018 VALID: Y and V SHALL hold stable until ack=1; E=0 in VALID SHALL NOT withdraw the outstanding code.
REQ-019 VALID with ack=1: pend[Y] SHALL be cleared per REQ-012, V SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-020 ack while V=0 SHALL be ignored.
REQ-021 Latency: D[i] pulse at edge n sets pend[i] after edge n; with FSM in IDLE and E=1, V=1 with Y=i after edge n+1.
REQ-022 Throughput: at most one code per two cycles, because IDLE is visited once between codes.
REQ-023 In IDLE, Y SHALL retain the last issued value.
REQ-024 Priority encoding SHALL be exact for all 256 pend values; pend=0 SHALL never produce V=1.

Reset
REQ-025 While rst=1: pend=8'h00, Y=3'b000, V=0, ovf=0, FSM=IDLE, regardless of clk.
REQ-026 Reset asserted mid-VALID SHALL discard the outstanding code and all pending requests; after release, behaviour restarts from IDLE.
REQ-027 Inputs sampled at the first rising edge after rst deasserts SHALL be honoured normally.

Verification
REQ-028 HIGH_FIRST=1, E=1, one-cycle D=8'b0010_0100, ack held 1 -> Y=5 with V=1, then Y=2 with V=1 two cycles later; pend ends 8'h00.
REQ-029 HIGH_FIRST=0, same stimulus -> Y=2 issued first, then Y=5.
REQ-030 V=1, Y=3, ack=1 and D=8'h08 in the same cycle -> pend[3] stays 1, ovf=0, Y=3 is reissued two cycles later.
REQ-031 pend=8'h01, D=8'h01 with ack=0 -> ovf=1 for exactly one cycle; pend stays 8'h01.
REQ-032 E=0 with D=8'hFF -> pend=8'hFF, V stays 0; raise E -> V=1 with Y=7 after one edge.
REQ-033 rst pulse while V=1, pend=8'h81 -> V=0, Y=0, pend=8'h00 immediately without a clock edge; no code issued until new D.
